frost32_irq_ctrl: RTL
=====================

Name: frost32_irq_ctrl

Overview:
Memory-mapped interrupt controller on the Frost32 CPU data bus, alongside main memory. It collects up to NUM_SOURCES external request lines, latches them as pending, masks them with an enable register, and drives the CPU's single interrupt input. Firmware reads and clears state through four 32-bit registers decoded at BASE_ADDR.

Parameters:
NUM_SOURCES, 8, number of interrupt request lines (1..32)
BASE_ADDR, 32'h0000_1000, byte address of register block (16-byte aligned)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
irq_src  in  NUM_SOURCES  asynchronous request lines from peripherals
req_mem_access  in  1  CPU bus request strobe
addr  in  32  CPU byte address
data_in  in  32  CPU write data
access_type  in  1  0 = read, 1 = write (DiatRead/DiatWrite)
access_size  in  2  0 = 32-bit, 1 = 16-bit, 2 = 8-bit
sel  out  1  combinational address hit: req_mem_access && addr[31:4]==BASE_ADDR[31:4]
data_out  out  32  read data
wait_for_mem  out  1  bus stall to CPU
interrupt  out  1  to CPU interrupt input

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Register map, offset = addr[3:2]:
  - 0 PENDING: read; write-1-to-clear.
  - 1 ENABLE: read/write.
  - 2 EDGE_MODE: read/write; 1 = edge-triggered, 0 = level.
  - 3 CLAIM: read-only; returns index+1 of the lowest-numbered set bit of PENDING&ENABLE, or 0 if none. Writes to CLAIM are ignored.
- Bits at and above NUM_SOURCES in any register read 0 and ignore writes.
- Only 32-bit accesses with addr[1:0]==0 take effect. Any other size or alignment completes the handshake normally, performs no write, and reads 0.
- Synchroniser: each irq_src bit passes through a 2-flop synchroniser, giving s[i]. A third flop, s_d[i], holds the previous s[i] for edge detection.
- Pending update, per bit, every cycle:
  - Edge mode: set on s & ~s_d. Cleared by a W1C write. If a set and a clear occur in the same cycle, set wins.
  - Level mode: pending = s. W1C has no lasting effect.
  - Changing EDGE_MODE takes effect the next cycle. Pending is not cleared on a mode change.
- interrupt: registered, equal to |(PENDING & ENABLE) as of the previous cycle. Latency from an irq_src rising edge to interrupt=1 is 4 clk.
- Bus FSM, states IDLE and ACCESS:
  - IDLE: wait_for_mem=0. If sel is 1 at a posedge, capture offset, access_type, access_size and data_in, then go to ACCESS.
  - ACCESS, one cycle: wait_for_mem=1. At the end of this cycle, perform the register write, or capture the read value into data_out. Then return to IDLE.
  - Read data is visible on data_out in the cycle after ACCESS and is held until the next completed read.
  - A CLAIM read reflects register state at the ACCESS cycle and has no side effects.
  - sel=0 requests are ignored entirely, and wait_for_mem stays 0.
  - A request arriving while in ACCESS is not accepted. The CPU holds req_mem_access; it is re-sampled in IDLE.
- Reset values: PENDING=0, ENABLE=0, EDGE_MODE=0, all synchroniser flops=0, state=IDLE, data_out=0, wait_for_mem=0, interrupt=0.
- Reset asserted mid-access aborts the access, with no register write, and forces all of the reset values above on the next posedge.

Test Plan:
- Reset, then read ENABLE at BASE_ADDR+4 -> wait_for_mem=1 for exactly 1 cycle, then data_out=32'h0; interrupt=0 throughout.
- Write ENABLE=32'h0000_0005 and EDGE_MODE=32'h0000_0001, then pulse irq_src[0] high for 1 cycle -> interrupt=1 4 cycles after the pulse; PENDING reads 32'h1; CLAIM reads 32'h1.
- Same setup, write PENDING=32'h1 -> interrupt=0 one cycle after PENDING clears. Repeat with a new edge on irq_src[0] in the same cycle as the W1C -> PENDING stays 1.
- Level mode, ENABLE=32'h4, hold irq_src[2]=1 -> PENDING=32'h4, CLAIM=32'h3. W1C to PENDING -> still reads 32'h4. Drop irq_src[2] -> PENDING=0 and interrupt=0 within 4 cycles.
- irq_src=8'h0A, all edge mode, ENABLE=8'hFF -> CLAIM=32'h2. Clear bit 1 -> CLAIM=32'h4. Clear bit 3 -> CLAIM=0.
- Byte write (access_size=2) of 32'hFF to ENABLE -> ENABLE unchanged. Access at BASE_ADDR+32'h10 -> sel=0 and wait_for_mem=0. Assert rst during ACCESS of an ENABLE write -> ENABLE=0 after reset.

Source files
------------

// File: rtl/frost32_irq_ctrl.sv
// Frost32 interrupt controller: synchronises request lines, latches them as pending,
// masks with ENABLE and exposes PENDING/ENABLE/EDGE_MODE/CLAIM on the CPU data bus.
module frost32_irq_ctrl #(
  parameter int unsigned NUM_SOURCES = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SOURCES-1:0] irq_src,
  input  logic                   req_mem_access,
  input  logic [31:0]            addr,
  input  logic [31:0]            data_in,
  input  logic                   access_type,
  input  logic [1:0]             access_size,
  output logic                   sel,
  output logic [31:0]            data_out,
  output logic                   wait_for_mem,
  output logic                   interrupt
);

  localparam int unsigned N = NUM_SOURCES;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_t;

  typedef enum logic [1:0] {
    REG_PENDING   = 2'd0,
    REG_ENABLE    = 2'd1,
    REG_EDGE_MODE = 2'd2,
    REG_CLAIM     = 2'd3
  } reg_off_t;

  function automatic logic [31:0] widen(input logic [N-1:0] v);
    widen        = '0;
    widen[N-1:0] = v;
  endfunction

  // Interrupt state
  logic [N-1:0] sync1;
  logic [N-1:0] s;
  logic [N-1:0] s_d;
  logic [N-1:0] pending;
  logic [N-1:0] enable;
  logic [N-1:0] edge_mode;

  // Bus transaction captured in IDLE, executed in ACCESS
  state_t       state;
  reg_off_t     off_q;
  logic         write_q;
  logic         valid_q;
  logic [N-1:0] wdata_q;

  logic [N-1:0] active;
  logic [N-1:0] rise;
  logic [N-1:0] w1c;
  logic [N-1:0] pending_next;
  logic         do_write;
  logic [31:0]  claim;
  logic [31:0]  rdata;

  assign sel = req_mem_access && (addr[31:4] == BASE_ADDR[31:4]);

  assign active   = pending & enable;
  assign rise     = s & ~s_d;
  assign do_write = (state == ST_ACCESS) && write_q && valid_q;
  assign w1c      = (do_write && off_q == REG_PENDING) ? wdata_q : '0;

  // Edge bits: a new edge in the same cycle as a W1C wins. Level bits track s.
  assign pending_next = (edge_mode & ((pending & ~w1c) | rise)) | (~edge_mode & s);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    claim = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (active[i]) claim = 32'(i + 1);
    end
  end

  always_comb begin
    rdata = '0;
    if (valid_q) begin
      unique case (off_q)
        REG_PENDING:   rdata = widen(pending);
        REG_ENABLE:    rdata = widen(enable);
        REG_EDGE_MODE: rdata = widen(edge_mode);
        REG_CLAIM:     rdata = claim;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      s         <= '0;
      s_d       <= '0;
      pending   <= '0;
      enable    <= '0;
      edge_mode <= '0;
      interrupt <= 1'b0;
    end else begin
      sync1     <= irq_src;
      s         <= sync1;
      s_d       <= s;
      pending   <= pending_next;
      interrupt <= |active;
      if (do_write && off_q == REG_ENABLE)    enable    <= wdata_q;
      if (do_write && off_q == REG_EDGE_MODE) edge_mode <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      off_q        <= REG_PENDING;
      write_q      <= 1'b0;
      valid_q      <= 1'b0;
      wdata_q      <= '0;
      data_out     <= '0;
      wait_for_mem <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (sel) begin
            state        <= ST_ACCESS;
            off_q        <= reg_off_t'(addr[3:2]);
            write_q      <= access_type;
            valid_q      <= (access_size == 2'd0) && (addr[1:0] == 2'b00);
            wdata_q      <= data_in[N-1:0];
            wait_for_mem <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (!write_q) data_out <= rdata;
          state        <= ST_IDLE;
          wait_for_mem <= 1'b0;
        end
      endcase
    end
  end

  // Write-data bits above the implemented sources are intentionally dropped.
  if (N < 32) begin : g_unused
    logic unused_data_hi;
    assign unused_data_hi = ^data_in[31:N];
  end

endmodule
